// File: rtl/spi_tx_queue_if.sv
// Handshake bundle between spi_tx_queue and its upstream writer / downstream SPI master.
// The flush input exists only when SPI_TX_QUEUE_FLUSH_EN is defined.
interface spi_tx_queue_if #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 16
);
  logic                     wr_en;
  logic [width-1:0]         wr_data;
  logic                     full;
  logic                     empty;
  logic [$clog2(depth):0]   count;
  logic                     ovf;
  logic                     busy;
  logic [width-1:0]         spi_din;
  logic                     spi_tx_vld;
  logic                     spi_done;
`ifdef SPI_TX_QUEUE_FLUSH_EN
  logic                     flush;
`endif

  modport slave (
    input  wr_en, wr_data, spi_done,
`ifdef SPI_TX_QUEUE_FLUSH_EN
    input  flush,
`endif
    output full, empty, count, ovf, busy, spi_din, spi_tx_vld
  );

  modport master (
    output wr_en, wr_data, spi_done,
`ifdef SPI_TX_QUEUE_FLUSH_EN
    output flush,
`endif
    input  full, empty, count, ovf, busy, spi_din, spi_tx_vld
  );
endinterface

// File: rtl/spi_tx_queue.sv
// Transmit FIFO plus frame sequencer feeding an SPI master one word per frame.
// Optional SPI_TX_QUEUE_FLUSH_EN adds a flush input that empties the queue.
module spi_tx_queue #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 16,
  parameter int unsigned gap   = 2
) (
  input logic            clk,
  input logic            rst,
  spi_tx_queue_if.slave  bus
);
  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = 4;

  typedef enum logic [1:0] {StIdle, StSend, StWait, StGap} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [width-1:0] din_q, din_d;
  logic [width-1:0] mem_q [depth];

  logic full, empty, flush, wr_acc, pop;

`ifdef SPI_TX_QUEUE_FLUSH_EN
  assign flush = bus.flush;
`else
  assign flush = 1'b0;
`endif

  assign full   = (count_q == CW'(depth));
  assign empty  = (count_q == '0);
  // A full FIFO rejects writes even when a pop frees a slot in the same cycle.
  assign wr_acc = bus.wr_en && !full && !flush;

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    din_d     = din_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty && !flush) begin
          pop     = 1'b1;
          din_d   = mem_q[rd_ptr_q];
          state_d = StSend;
        end
      end
      StSend: state_d = StWait;
      StWait: begin
        if (bus.spi_done) begin
          if (gap == 0) begin
            state_d = StIdle;
          end else begin
            state_d   = StGap;
            gap_cnt_d = GW'(gap);
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (bus.wr_en && full);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({wr_acc, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      gap_cnt_q <= '0;
      din_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      gap_cnt_q <= gap_cnt_d;
      din_q     <= din_d;
    end
  end

  // Storage needs no reset; occupancy is governed by the pointers and count.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.count      = count_q;
  assign bus.ovf        = ovf_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.spi_din    = din_q;
  assign bus.spi_tx_vld = (state_q == StSend);
endmodule
